// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and rate constants for divided-clock producers and consumers
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUNNING, STALLED} mon_state_e;
  localparam int SYS_CLK_HZ = 100_000_000;
  localparam int TICK_HZ = 10;
  localparam int TICK_PERIOD = SYS_CLK_HZ / TICK_HZ;
  // 1.2x the nominal tick period before a divider is considered dead
  localparam int TICK_TIMEOUT = TICK_PERIOD / 5 * 6;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizes a slow asynchronous level and emits registered rise/fall strobes
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  always_ff @(posedge clk_100MHz or posedge rst)
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      hist <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~hist;
      fall <= ~sync[SYNC_STAGES-1] & hist;
    end
endmodule

// File: rtl/divided_clock_monitor.sv
// divided_clock_monitor: turns a slow divided clock into strobes, period, beat count and stall flag
module divided_clock_monitor
  import clk_div_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W = 24,
  parameter int TIMEOUT = TICK_TIMEOUT,
  parameter int BEAT_W = 16
) (
  input  logic                clk_100MHz,
  input  logic                rst,
  input  logic                clk_div_in,
  output logic                tick_rise,
  output logic                tick_fall,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [BEAT_W-1:0]   beat_count,
  output logic                stalled
);
  // idle is sized to hold TIMEOUT even when the period counter is narrower
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] TO = IDLE_W'(TIMEOUT);
  logic rise, fall, timeout, valid_nx, stalled_nx;
  logic [PERIOD_W-1:0] meas, period_nx;
  logic [IDLE_W-1:0] idle, idle_nx;
  mon_state_e state, state_nx;
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_100MHz(clk_100MHz),
    .rst(rst),
    .d(clk_div_in),
    .rise(rise),
    .fall(fall)
  );
  always_comb begin
    idle_nx = (rise | fall) ? '0 : (idle == TO) ? idle : idle + IDLE_W'(1);
    timeout = idle_nx == TO;
    state_nx = state;
    period_nx = period;
    valid_nx = period_valid;
    stalled_nx = stalled;
    case (state)
      IDLE: state_nx = rise ? ARMED : IDLE;
      ARMED: if (rise) begin
        state_nx = RUNNING;
        period_nx = meas;
        valid_nx = 1'b1;
      end
      RUNNING: period_nx = rise ? meas : period;
      STALLED: if (rise | fall) begin
        state_nx = rise ? ARMED : IDLE;
        stalled_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
    // a strobe clears idle_nx, so a coincident rise always beats the timeout
    if (timeout && state != STALLED) begin
      state_nx = STALLED;
      stalled_nx = 1'b1;
      valid_nx = 1'b0;
    end
  end
  always_ff @(posedge clk_100MHz or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_100MHz or posedge rst)
    if (rst) begin
      meas <= '0;
      idle <= '0;
      period <= '0;
      period_valid <= 1'b0;
      stalled <= 1'b0;
      beat_count <= '0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      meas <= rise ? PERIOD_W'(1) : (&meas) ? meas : meas + PERIOD_W'(1);
      idle <= idle_nx;
      period <= period_nx;
      period_valid <= valid_nx;
      stalled <= stalled_nx;
      beat_count <= beat_count + BEAT_W'(rise);
      tick_rise <= rise;
      tick_fall <= fall;
    end
endmodule

// File: tb/tb_divided_clock_monitor.sv
// tb_divided_clock_monitor: randomized scoreboard bench against a timestamp-based reference model
module tb_divided_clock_monitor;
  localparam int S = 2;
  localparam int PW = 8;
  localparam int T = 300;
  localparam int BW = 4;
  localparam int PMAX = (1 << PW) - 1;
  logic clk_100MHz = 1'b0;
  logic rst = 1'b1;
  logic clk_div_in = 1'b0;
  logic tick_rise, tick_fall, period_valid, stalled;
  logic [PW-1:0] period;
  logic [BW-1:0] beat_count;
  logic stl_q = 1'b0;
  typedef struct {int t; bit r;} stim_t;
  typedef struct {int t; int kind; int per; bit val; int beats; bit stl;} exp_t;
  stim_t pend[$];
  exp_t sb[$];
  int cyc = 0, total = 0, bad = 0;
  int ph = 0, last_evt = 0, last_rise = 0, m_per = 0, m_beats = 0;
  bit m_val = 0, m_stl = 0;
  divided_clock_monitor #(.SYNC_STAGES(S), .PERIOD_W(PW), .TIMEOUT(T), .BEAT_W(BW)) dut (
    .clk_100MHz(clk_100MHz),
    .rst(rst),
    .clk_div_in(clk_div_in),
    .tick_rise(tick_rise),
    .tick_fall(tick_fall),
    .period(period),
    .period_valid(period_valid),
    .beat_count(beat_count),
    .stalled(stalled)
  );
  always #5 clk_100MHz = ~clk_100MHz;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cycle=%0d", n, a, e, cyc);
    end
  endtask
  function automatic void push_stim(input int t, input bit r);
    stim_t s;
    s.t = t;
    s.r = r;
    pend.push_back(s);
  endfunction
  function automatic void push_exp(input int kind);
    exp_t e;
    e.t = cyc;
    e.kind = kind;
    e.per = m_per;
    e.val = m_val;
    e.beats = m_beats;
    e.stl = m_stl;
    sb.push_back(e);
  endfunction
  // model: phases 0 idle, 1 armed, 2 running, 3 stalled; times are posedge numbers
  always @(posedge clk_100MHz) begin
    stim_t s;
    cyc++;
    if (rst) begin
      ph = 0;
      last_evt = cyc;
      m_per = 0;
      m_val = 0;
      m_stl = 0;
      m_beats = 0;
      pend.delete();
    end else if (pend.size() > 0 && pend[0].t == cyc) begin
      s = pend.pop_front();
      last_evt = cyc;
      if (s.r) begin
        if (ph == 1 || ph == 2) m_per = (cyc - last_rise > PMAX) ? PMAX : cyc - last_rise;
        if (ph == 1) m_val = 1;
        ph = (ph == 1 || ph == 2) ? 2 : 1;
        m_stl = 0;
        last_rise = cyc;
        m_beats = (m_beats + 1) % (1 << BW);
      end else if (ph == 3) begin
        ph = 0;
        m_stl = 0;
      end
      push_exp(s.r ? 1 : 2);
    end else if (ph != 3 && cyc - last_evt == T) begin
      ph = 3;
      m_stl = 1;
      m_val = 0;
      push_exp(3);
    end
  end
  always @(negedge clk_100MHz) begin
    exp_t e;
    int k;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].t < cyc) begin
        e = sb.pop_front();
        chk("missed_event_kind", 0, e.kind);
      end
      k = (tick_rise && tick_fall) ? 4 : tick_rise ? 1 : tick_fall ? 2 : (stalled && !stl_q) ? 3 : 0;
      if (k != 0) begin
        if (sb.size() == 0 || sb[0].t != cyc) chk("event_time", cyc, sb.size() > 0 ? sb[0].t : -1);
        else begin
          e = sb.pop_front();
          chk("kind", k, e.kind);
          chk("period", int'(period), e.per);
          chk("period_valid", int'(period_valid), int'(e.val));
          chk("beat_count", int'(beat_count), e.beats);
          chk("stalled", int'(stalled), int'(e.stl));
        end
      end
    end
    stl_q = stalled;
  end
  task automatic drive(input logic v);
    if (v != clk_div_in) push_stim(cyc + S + 2, v);
    clk_div_in = v;
  endtask
  task automatic tog(input int h);
    repeat (h) @(negedge clk_100MHz);
    drive(~clk_div_in);
  endtask
  task automatic quiet();
    for (int i = 0; i < 2000 && (pend.size() + sb.size()) > 0; i++) @(negedge clk_100MHz);
    @(negedge clk_100MHz);
  endtask
  task automatic check_zero(input string n);
    chk({n, "_tick_rise"}, int'(tick_rise), 0);
    chk({n, "_tick_fall"}, int'(tick_fall), 0);
    chk({n, "_period"}, int'(period), 0);
    chk({n, "_period_valid"}, int'(period_valid), 0);
    chk({n, "_beat_count"}, int'(beat_count), 0);
    chk({n, "_stalled"}, int'(stalled), 0);
  endtask
  task automatic release_rst();
    rst = 1'b0;
    if (clk_div_in) push_stim(cyc + S + 2, 1'b1);
  endtask
  initial begin
    repeat (3) @(negedge clk_100MHz);
    check_zero("reset");
    release_rst();
    for (int i = 0; i < 9; i++) tog(50);
    repeat (400) @(negedge clk_100MHz);
    for (int i = 0; i < 8; i++) tog(50);
    tog(300);
    tog(300);
    tog(301);
    for (int i = 0; i < 3; i++) tog(50);
    for (int i = 0; i < 5; i++) tog(200);
    for (int i = 0; i < 40; i++) tog(10);
    if (!clk_div_in) tog(10);
    quiet();
    @(negedge clk_100MHz);
    #1 rst = 1'b1;
    #1 check_zero("async_reset");
    repeat (3) @(negedge clk_100MHz);
    release_rst();
    for (int i = 0; i < 6; i++) tog(50);
    for (int i = 0; i < 150; i++)
      tog(($urandom_range(0, 9) == 0) ? $urandom_range(280, 320) : $urandom_range(3, 120));
    quiet();
    chk("scoreboard_drained", pend.size() + sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
